// File: rtl/dadda_pkg.sv
// Shared constants and Dadda height-target helpers for the pipelined multiplier.
package dadda_pkg;

    localparam int unsigned LATENCY = 3;

    // Dadda height sequence: d(0)=2, d(j+1)=floor(1.5*d(j)).
    function automatic int unsigned dadda_height(input int unsigned j);
        int unsigned d;
        d = 2;
        for (int unsigned k = 0; k < 16; k++) begin
            if (k < j) d = (d * 3) / 2;
        end
        return d;
    endfunction

    // Number of reduction stages for a WIDTH x WIDTH matrix (max column height WIDTH).
    function automatic int unsigned dadda_stages(input int unsigned width);
        int unsigned n;
        n = 0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (dadda_height(k) < width) n = k + 1;
        end
        return n;
    endfunction

    // Height target of reduction stage s (s=0 is the first stage applied).
    function automatic int unsigned dadda_target(input int unsigned width, input int unsigned s);
        return dadda_height(dadda_stages(width) - 1 - s);
    endfunction

endpackage

// File: rtl/dadda_reduce.sv
// Combinational Baugh-Wooley partial-product generation and Dadda reduction to two rows.
module dadda_reduce
    import dadda_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] row0,
    output logic [2*WIDTH-1:0] row1
);

    localparam int unsigned COLS = 2 * WIDTH;
    localparam int unsigned MAXH = WIDTH + 1;
    localparam int unsigned CW   = $clog2(COLS);
    localparam int unsigned RW   = $clog2(MAXH);
    localparam int unsigned IW   = $clog2(WIDTH);
    localparam int unsigned NST  = dadda_stages(WIDTH);

    typedef logic [MAXH-1:0] col_t;

    always_comb begin
        col_t        cur [COLS];
        col_t        nxt [COLS];
        int unsigned hc  [COLS];
        int unsigned hn  [COLS];
        int unsigned d, idx, total, col;
        logic        x, y, z, sum, cry;

        d = 0; idx = 0; total = 0; col = 0;
        x = 1'b0; y = 1'b0; z = 1'b0; sum = 1'b0; cry = 1'b0;
        row0 = '0;
        row1 = '0;
        for (int unsigned k = 0; k < COLS; k++) begin
            cur[CW'(k)] = '0;
            nxt[CW'(k)] = '0;
            hc[CW'(k)]  = 0;
            hn[CW'(k)]  = 0;
        end

        // Modified Baugh-Wooley: invert the cross terms with one sign bit, add 1s at WIDTH and 2*WIDTH-1.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                col = i + j;
                cur[CW'(col)][RW'(hc[CW'(col)])] = (a[IW'(j)] & b[IW'(i)]) ^
                    (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
                hc[CW'(col)] = hc[CW'(col)] + 1;
            end
        end
        cur[CW'(WIDTH)][RW'(hc[CW'(WIDTH)])] = signed_mode;
        hc[CW'(WIDTH)] = hc[CW'(WIDTH)] + 1;
        cur[CW'(COLS-1)][RW'(hc[CW'(COLS-1)])] = signed_mode;
        hc[CW'(COLS-1)] = hc[CW'(COLS-1)] + 1;

        for (int unsigned st = 0; st < NST; st++) begin
            d = dadda_target(WIDTH, st);
            for (int unsigned k = 0; k < COLS; k++) begin
                nxt[CW'(k)] = '0;
                hn[CW'(k)]  = 0;
            end
            // Incoming carries already sit in nxt[col]; a half adder is used only when one bit too many.
            for (int unsigned k = 0; k < COLS; k++) begin
                col   = k;
                idx   = 0;
                total = hc[CW'(col)] + hn[CW'(col)];
                for (int unsigned t = 0; t < MAXH; t++) begin
                    if (total > d) begin
                        x = cur[CW'(col)][RW'(idx)];
                        y = cur[CW'(col)][RW'(idx + 1)];
                        if (total == d + 1) begin
                            sum   = x ^ y;
                            cry   = x & y;
                            idx   = idx + 2;
                            total = total - 1;
                        end else begin
                            z     = cur[CW'(col)][RW'(idx + 2)];
                            sum   = x ^ y ^ z;
                            cry   = (x & y) | (x & z) | (y & z);
                            idx   = idx + 3;
                            total = total - 2;
                        end
                        nxt[CW'(col)][RW'(hn[CW'(col)])] = sum;
                        hn[CW'(col)] = hn[CW'(col)] + 1;
                        if (col + 1 < COLS) begin
                            nxt[CW'(col + 1)][RW'(hn[CW'(col + 1)])] = cry;
                            hn[CW'(col + 1)] = hn[CW'(col + 1)] + 1;
                        end
                    end
                end
                for (int unsigned r = 0; r < MAXH; r++) begin
                    if (r >= idx && r < hc[CW'(col)]) begin
                        nxt[CW'(col)][RW'(hn[CW'(col)])] = cur[CW'(col)][RW'(r)];
                        hn[CW'(col)] = hn[CW'(col)] + 1;
                    end
                end
            end
            cur = nxt;
            hc  = hn;
        end

        for (int unsigned k = 0; k < COLS; k++) begin
            row0[CW'(k)] = cur[CW'(k)][0];
            row1[CW'(k)] = cur[CW'(k)][1];
        end
    end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined signed/unsigned Dadda multiplier with valid/ready handshake and tag sideband.
module dadda_mult_pipe
    import dadda_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
);

    logic               adv;
    logic               v1, v2;
    logic [WIDTH-1:0]   a1, b1;
    logic               sg1;
    logic [TAG_W-1:0]   t1, t2;
    logic [2*WIDTH-1:0] r0, r1, r0_q, r1_q;

    // Whole pipeline moves in lockstep, so in_ready never depends on in_valid.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    dadda_reduce #(.WIDTH(WIDTH)) u_reduce (
        .a           (a1),
        .b           (b1),
        .signed_mode (sg1),
        .row0        (r0),
        .row1        (r1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid   <= 1'b0;
            a1          <= '0;
            b1          <= '0;
            sg1         <= 1'b0;
            t1          <= '0;
            t2          <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            out_product <= '0;
            out_tag     <= '0;
        end else if (adv) begin
            v1          <= in_valid;
            a1          <= in_a;
            b1          <= in_b;
            sg1         <= in_signed;
            t1          <= in_tag;
            v2          <= v1;
            r0_q        <= r0;
            r1_q        <= r1;
            t2          <= t1;
            out_valid   <= v2;
            out_product <= r0_q + r1_q;
            out_tag     <= t2;
        end
    end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Directed and randomized self-checking bench for dadda_mult_pipe at WIDTH 8, 16 and 5.
module tb_dadda_mult_pipe;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic        d8_in_valid, d8_in_ready, d8_in_signed, d8_out_valid, d8_out_ready;
    logic [7:0]  d8_in_a, d8_in_b;
    logic [3:0]  d8_in_tag, d8_out_tag;
    logic [15:0] d8_out_product;

    logic        d16_in_valid, d16_in_ready, d16_in_signed, d16_out_valid, d16_out_ready;
    logic [15:0] d16_in_a, d16_in_b;
    logic [3:0]  d16_in_tag, d16_out_tag;
    logic [31:0] d16_out_product;

    logic        d5_in_valid, d5_in_ready, d5_in_signed, d5_out_valid, d5_out_ready;
    logic [4:0]  d5_in_a, d5_in_b;
    logic [3:0]  d5_in_tag, d5_out_tag;
    logic [9:0]  d5_out_product;

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
        int          c;
    } exp_t;

    exp_t q[$];

    dadda_mult_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .in_a(d8_in_a), .in_b(d8_in_b), .in_signed(d8_in_signed), .in_tag(d8_in_tag),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .out_product(d8_out_product), .out_tag(d8_out_tag)
    );

    dadda_mult_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .in_a(d16_in_a), .in_b(d16_in_b), .in_signed(d16_in_signed), .in_tag(d16_in_tag),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .out_product(d16_out_product), .out_tag(d16_out_tag)
    );

    dadda_mult_pipe #(.WIDTH(5), .TAG_W(4)) u5 (
        .clk(clk), .rst(rst), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .in_a(d5_in_a), .in_b(d5_in_b), .in_signed(d5_in_signed), .in_tag(d5_in_tag),
        .out_valid(d5_out_valid), .out_ready(d5_out_ready),
        .out_product(d5_out_product), .out_tag(d5_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference product modulo 2^(2w), operands sign-extended when sg is set.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg, input int unsigned w);
        logic [63:0] x, y, m;
        x = {32'd0, a};
        y = {32'd0, b};
        if (sg && ((x >> (w - 1)) & 64'd1) != 64'd0) x = x | (~64'd0 << w);
        if (sg && ((y >> (w - 1)) & 64'd1) != 64'd0) y = y | (~64'd0 << w);
        m = (~64'd0) >> (64 - 2 * w);
        return (x * y) & m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        d8_in_valid = 1'b1; d8_in_a = 8'h12; d8_in_b = 8'h34; d8_in_signed = 1'b0;
        d8_in_tag = 4'h5; d8_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", d8_out_valid); end
        n_checks++; if (d8_out_product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", d8_out_product); end
        n_checks++; if (d8_out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", d8_out_tag); end
        rst = 1'b0;
        d8_in_valid = 1'b0;
        #1;
        n_checks++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", d8_in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_handshake_ignored: cycle %0d out_valid %b expected 0", k, d8_out_valid); end
        end
    endtask

    task automatic test_max_unsigned();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            d8_out_ready = 1'b1;
            if (k == 0) begin
                d8_in_valid = 1'b1; d8_in_a = 8'hFF; d8_in_b = 8'hFF; d8_in_signed = 1'b0; d8_in_tag = 4'd3;
            end else begin
                d8_in_valid = 1'b0;
            end
            #1;
            n_checks++; if (d8_out_valid !== (k == 3)) begin n_fail++; $display("FAIL max_latency: cycle %0d out_valid %b expected %b", k, d8_out_valid, (k == 3)); end
            if (k == 3) begin
                n_checks++; if (d8_out_product !== 16'hFE01) begin n_fail++; $display("FAIL max_product: got %h expected FE01", d8_out_product); end
                n_checks++; if (d8_out_tag !== 4'd3) begin n_fail++; $display("FAIL max_tag: got %h expected 3", d8_out_tag); end
            end
        end
    endtask

    task automatic test_signed_back_to_back();
        logic [7:0]  va [4] = '{8'h80, 8'hFF, 8'h80, 8'hFF};
        logic [7:0]  vb [4] = '{8'h80, 8'h01, 8'h7F, 8'h01};
        logic        vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] vp [4] = '{16'h4000, 16'hFFFF, 16'hC080, 16'h00FF};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d8_out_ready = 1'b1;
            if (k < 4) begin
                d8_in_valid = 1'b1; d8_in_a = va[k]; d8_in_b = vb[k]; d8_in_signed = vs[k]; d8_in_tag = 4'(k + 1);
            end else begin
                d8_in_valid = 1'b0;
            end
            #1;
            n_checks++; if (d8_out_valid !== (k >= 3 && k <= 6)) begin n_fail++; $display("FAIL signed_valid: cycle %0d out_valid %b", k, d8_out_valid); end
            if (k >= 3 && k <= 6) begin
                n_checks++; if (d8_out_product !== vp[k-3]) begin n_fail++; $display("FAIL signed_product: op %0d got %h expected %h", k - 3, d8_out_product, vp[k-3]); end
                n_checks++; if (d8_out_tag !== 4'(k - 2)) begin n_fail++; $display("FAIL signed_tag: op %0d got %h expected %h", k - 3, d8_out_tag, 4'(k - 2)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int          issued = 0;
        int          expect_tag = 0;
        logic        stalled = 1'b0;
        logic [15:0] held_p = '0;
        logic [3:0]  held_t = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            d8_out_ready = !(k >= 4 && k <= 9);
            if (issued < 6) begin
                d8_in_valid = 1'b1; d8_in_a = 8'(10 + issued); d8_in_b = 8'd3; d8_in_signed = 1'b0; d8_in_tag = 4'(issued);
            end else begin
                d8_in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                n_checks++; if (d8_out_valid !== 1'b1 || d8_out_product !== held_p || d8_out_tag !== held_t) begin
                    n_fail++; $display("FAIL bp_stable: cycle %0d got %b/%h/%h expected 1/%h/%h", k, d8_out_valid, d8_out_product, d8_out_tag, held_p, held_t);
                end
            end
            if (d8_out_valid && !d8_out_ready) begin
                n_checks++; if (d8_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", k, d8_in_ready); end
            end
            if (d8_out_valid && d8_out_ready) begin
                n_checks++; if (d8_out_tag !== 4'(expect_tag) || d8_out_product !== 16'((10 + expect_tag) * 3)) begin
                    n_fail++; $display("FAIL bp_order: got tag %h product %h expected tag %h product %h", d8_out_tag, d8_out_product, 4'(expect_tag), 16'((10 + expect_tag) * 3));
                end
                expect_tag++;
            end
            stalled = d8_out_valid && !d8_out_ready;
            held_p  = d8_out_product;
            held_t  = d8_out_tag;
            if (d8_in_valid && d8_in_ready) issued++;
        end
        n_checks++; if (expect_tag != 6) begin n_fail++; $display("FAIL bp_count: got %0d results expected 6", expect_tag); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            d8_out_ready = 1'b1;
            d8_in_valid = 1'b1; d8_in_a = 8'(k + 2); d8_in_b = 8'd7; d8_in_signed = 1'b0; d8_in_tag = 4'(k + 8);
        end
        @(negedge clk);
        d8_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", d8_out_valid); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale: cycle %0d out_valid %b tag %h", k, d8_out_valid, d8_out_tag); end
        end
    endtask

    task automatic test_random16();
        int   acc = 0;
        int   guard = 0;
        exp_t e;
        q.delete();
        while ((acc < 2000 || q.size() != 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
            d16_out_ready = ($urandom_range(0, 3) != 0);
            d16_in_valid  = (acc < 2000) && ($urandom_range(0, 3) != 0);
            d16_in_a      = 16'($urandom);
            d16_in_b      = 16'($urandom);
            d16_in_signed = 1'($urandom);
            d16_in_tag    = 4'(acc);
            #1;
            if (d16_out_valid && d16_out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand16_extra: unexpected result %h tag %h", d16_out_product, d16_out_tag);
                end else begin
                    e = q.pop_front();
                    if (d16_out_product !== e.p[31:0] || d16_out_tag !== e.tag) begin
                        n_fail++; $display("FAIL rand16_result: got %h/%h expected %h/%h", d16_out_product, d16_out_tag, e.p[31:0], e.tag);
                    end
                    n_checks++; if (cyc - e.c < 3) begin n_fail++; $display("FAIL rand16_latency: got %0d expected >= 3", cyc - e.c); end
                end
            end
            if (d16_in_valid && d16_in_ready) begin
                e.p = ref_mul(32'(d16_in_a), 32'(d16_in_b), d16_in_signed, 16);
                e.tag = d16_in_tag; e.c = cyc;
                q.push_back(e);
                acc++;
            end
        end
        d16_in_valid = 1'b0;
        n_checks++; if (acc != 2000 || q.size() != 0) begin n_fail++; $display("FAIL rand16_drain: accepted %0d pending %0d expected 2000/0", acc, q.size()); end
    endtask

    task automatic test_random5();
        int   acc = 0;
        int   guard = 0;
        exp_t e;
        q.delete();
        while ((acc < 2000 || q.size() != 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
            d5_out_ready = ($urandom_range(0, 3) != 0);
            d5_in_valid  = (acc < 2000) && ($urandom_range(0, 3) != 0);
            d5_in_a      = 5'($urandom);
            d5_in_b      = 5'($urandom);
            d5_in_signed = 1'($urandom);
            d5_in_tag    = 4'(acc);
            #1;
            if (d5_out_valid && d5_out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand5_extra: unexpected result %h tag %h", d5_out_product, d5_out_tag);
                end else begin
                    e = q.pop_front();
                    if (d5_out_product !== e.p[9:0] || d5_out_tag !== e.tag) begin
                        n_fail++; $display("FAIL rand5_result: got %h/%h expected %h/%h", d5_out_product, d5_out_tag, e.p[9:0], e.tag);
                    end
                    n_checks++; if (cyc - e.c < 3) begin n_fail++; $display("FAIL rand5_latency: got %0d expected >= 3", cyc - e.c); end
                end
            end
            if (d5_in_valid && d5_in_ready) begin
                e.p = ref_mul(32'(d5_in_a), 32'(d5_in_b), d5_in_signed, 5);
                e.tag = d5_in_tag; e.c = cyc;
                q.push_back(e);
                acc++;
            end
        end
        d5_in_valid = 1'b0;
        n_checks++; if (acc != 2000 || q.size() != 0) begin n_fail++; $display("FAIL rand5_drain: accepted %0d pending %0d expected 2000/0", acc, q.size()); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        d8_in_valid = 1'b0;  d8_in_a = '0;  d8_in_b = '0;  d8_in_signed = 1'b0;  d8_in_tag = '0;  d8_out_ready = 1'b1;
        d16_in_valid = 1'b0; d16_in_a = '0; d16_in_b = '0; d16_in_signed = 1'b0; d16_in_tag = '0; d16_out_ready = 1'b1;
        d5_in_valid = 1'b0;  d5_in_a = '0;  d5_in_b = '0;  d5_in_signed = 1'b0;  d5_in_tag = '0;  d5_out_ready = 1'b1;

        test_reset();
        test_max_unsigned();
        test_signed_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random16();
        test_random5();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
